// File: rtl/image_store_buffer_sched.sv
// ---------------------------------------------------------------------------
// image_store_buffer_sched
//
// Frame-buffer rotation scheduler for the image store write path. Once per
// frame it arms the Avalon-MM store master with a one-cycle enable and a
// buffer base address. Writes rotate across NUM_BUF buffers in DDR. The
// newest complete buffer can be handed to a reader and locked there. The
// writer never targets the locked buffer or the newest complete buffer.
//
// Parameters
//   NUM_BUF  buffers in rotation (3..8)
//   ADDR_W   address width
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   cfg_base         address of buffer 0
//   cfg_frame_bytes  stride between buffers
//   cfg_continuous   1: re-arm after every frame, 0: one frame then idle
//   cfg_start        pulse, start scheduling (only honoured in IDLE)
//   cfg_stop         pulse, stop once the current frame completes
//   wr_en            one-cycle arm pulse to the store master
//   wr_address       target buffer address, held from ARM through COMMIT
//   wr_done          pulse from the store master, frame written
//   busy             scheduler not IDLE
//   rd_req           pulse, reader asks for the newest frame
//   rd_grant         one-cycle pulse, rd_address valid and buffer locked
//   rd_address       locked buffer address, held until the next grant
//   rd_release       pulse, reader finished with the locked buffer
//   frame_cnt        committed frames, wraps at 2^32
//   drop_cnt         (IMAGE_STORE_DROP_CNT_EN only) count of frames that
//                    were overwritten before a reader took them, saturating
//
// Optional feature macro: IMAGE_STORE_DROP_CNT_EN
// ---------------------------------------------------------------------------
module image_store_buffer_sched #(
  parameter  int NUM_BUF = 3,
  parameter  int ADDR_W  = 32,
  localparam int IDX_W   = $clog2(NUM_BUF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_frame_bytes,
  input  logic              cfg_continuous,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_address,
  input  logic              wr_done,
  output logic              busy,
  input  logic              rd_req,
  output logic              rd_grant,
  output logic [ADDR_W-1:0] rd_address,
  input  logic              rd_release,
  output logic [31:0]       frame_cnt
`ifdef IMAGE_STORE_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_ARM,
    S_WAIT,
    S_COMMIT
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  wr_idx;
  logic              stop_flag;

  // Newest complete frame
  logic              latest_valid;
  logic [IDX_W-1:0]  latest_idx;
  logic [ADDR_W-1:0] latest_addr;

  // Buffer currently held by the reader
  logic              lock_valid;
  logic [IDX_W-1:0]  lock_idx;

  logic [IDX_W-1:0]  pick_idx;
  logic [ADDR_W-1:0] pick_addr;
  logic              grant_now;
  logic              commit_now;

  // Lowest buffer index that is neither the newest frame nor the locked one.
  // With at least three buffers such an index always exists.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, otherwise paths that skip an assignment infer a latch.
    pick_idx = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (!(latest_valid && latest_idx == IDX_W'(i)) &&
          !(lock_valid   && lock_idx   == IDX_W'(i)))
        pick_idx = IDX_W'(i);
    end
    pick_addr = cfg_base + ADDR_W'(pick_idx) * cfg_frame_bytes;
  end

  // Release has priority over a request in the same cycle.
  assign grant_now  = !rd_release && rd_req && latest_valid && !lock_valid;
  assign commit_now = (state == S_COMMIT);

  // Write scheduler FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      wr_en        <= 1'b0;
      wr_address   <= '0;
      wr_idx       <= '0;
      busy         <= 1'b0;
      frame_cnt    <= '0;
      stop_flag    <= 1'b0;
      latest_valid <= 1'b0;
      latest_idx   <= '0;
      latest_addr  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      wr_en <= 1'b0;

      if (state != S_IDLE && cfg_stop)
        stop_flag <= 1'b1;

      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            state <= S_PICK;
            busy  <= 1'b1;
          end
        end
        S_PICK: begin
          // Config is sampled here and nowhere else during a frame.
          wr_idx     <= pick_idx;
          wr_address <= pick_addr;
          wr_en      <= 1'b1;
          state      <= S_ARM;
        end
        S_ARM: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wr_done)
            state <= S_COMMIT;
        end
        S_COMMIT: begin
          latest_idx   <= wr_idx;
          latest_addr  <= wr_address;
          latest_valid <= 1'b1;
          frame_cnt    <= frame_cnt + 32'd1;
          if (cfg_continuous && !stop_flag && !cfg_stop) begin
            state <= S_PICK;
          end else begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            stop_flag <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Reader hand-off. A request in the COMMIT cycle sees the pre-commit latest
  // frame, because latest_* only updates at the end of that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_grant   <= 1'b0;
      rd_address <= '0;
      lock_valid <= 1'b0;
      lock_idx   <= '0;
    end else begin
      rd_grant <= 1'b0;
      if (rd_release) begin
        lock_valid <= 1'b0;
      end else if (grant_now) begin
        rd_grant   <= 1'b1;
        rd_address <= latest_addr;
        lock_valid <= 1'b1;
        lock_idx   <= latest_idx;
      end
    end
  end

`ifdef IMAGE_STORE_DROP_CNT_EN
  // latest_granted tracks whether the current newest frame has been given to
  // a reader. A commit that replaces an ungranted frame counts as a drop.
  logic latest_granted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latest_granted <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      if (commit_now) begin
        latest_granted <= 1'b0;
        if (latest_valid && !latest_granted && !grant_now &&
            drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end else if (grant_now) begin
        latest_granted <= 1'b1;
      end
    end
  end
`else
  logic unused_commit;
  assign unused_commit = commit_now;
`endif

endmodule

// File: tb/tb_image_store_buffer_sched.sv
// ---------------------------------------------------------------------------
// tb_image_store_buffer_sched
//
// Directed bench for image_store_buffer_sched (NUM_BUF=3, ADDR_W=32).
// Inputs change 1 time unit after the rising edge, and outputs are sampled
// at the same point, so each tick() advances exactly one clock cycle.
// ---------------------------------------------------------------------------
module tb_image_store_buffer_sched;

  localparam logic [31:0] BASE   = 32'h0040_0000;
  localparam logic [31:0] STRIDE = 32'h0010_0000;
  localparam logic [31:0] BUF0   = 32'h0040_0000;
  localparam logic [31:0] BUF1   = 32'h0050_0000;
  localparam logic [31:0] BUF2   = 32'h0060_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_base;
  logic [31:0] cfg_frame_bytes;
  logic        cfg_continuous;
  logic        cfg_start;
  logic        cfg_stop;
  logic        wr_en;
  logic [31:0] wr_address;
  logic        wr_done;
  logic        busy;
  logic        rd_req;
  logic        rd_grant;
  logic [31:0] rd_address;
  logic        rd_release;
  logic [31:0] frame_cnt;
`ifdef IMAGE_STORE_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  image_store_buffer_sched #(.NUM_BUF(3), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_base        (cfg_base),
    .cfg_frame_bytes (cfg_frame_bytes),
    .cfg_continuous  (cfg_continuous),
    .cfg_start       (cfg_start),
    .cfg_stop        (cfg_stop),
    .wr_en           (wr_en),
    .wr_address      (wr_address),
    .wr_done         (wr_done),
    .busy            (busy),
    .rd_req          (rd_req),
    .rd_grant        (rd_grant),
    .rd_address      (rd_address),
    .rd_release      (rd_release),
    .frame_cnt       (frame_cnt)
`ifdef IMAGE_STORE_DROP_CNT_EN
    ,
    .drop_cnt        (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst             = 1'b1;
    cfg_base        = BASE;
    cfg_frame_bytes = STRIDE;
    cfg_continuous  = 1'b1;
    cfg_start       = 1'b0;
    cfg_stop        = 1'b0;
    wr_done         = 1'b0;
    rd_req          = 1'b0;
    rd_release      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // Wait (bounded) for the next arm pulse and compare its address.
  task automatic wait_arm(input logic [31:0] exp, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = wr_en;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: wr_en never rose within 20 cycles", name);
    end else if (wr_address !== exp) begin
      errors++;
      $display("FAIL %s: wr_address got %h expected %h", name, wr_address, exp);
    end
  endtask

  // From the ARM cycle: move into WAIT, pulse wr_done, end in COMMIT.
  task automatic finish_frame();
    tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_en, busy, rd_grant} !== 3'b000 || wr_address !== 32'h0 ||
        rd_address !== 32'h0 || frame_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: wr_en=%b busy=%b rd_grant=%b wr_address=%h rd_address=%h frame_cnt=%0d expected all zero",
               wr_en, busy, rd_grant, wr_address, rd_address, frame_cnt);
    end
    apply_reset();
  endtask

  // T1 plus stop-during-WAIT: exact latencies and rotation without a reader.
  task automatic test_continuous();
    apply_reset();
    pulse_start();                      // now in PICK
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_plus1: wr_en=%b busy=%b expected 0 1", wr_en, busy);
    end
    tick();                             // ARM, cfg_start cycle + 2
    checks++;
    if (wr_en !== 1'b1 || wr_address !== BUF0) begin
      errors++;
      $display("FAIL start_plus2: wr_en=%b wr_address=%h expected 1 %h", wr_en, wr_address, BUF0);
    end
    tick();                             // WAIT
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL arm_one_cycle: wr_en got %b expected 0", wr_en);
    end
    wr_done = 1'b1;
    tick();                             // COMMIT (wr_done + 1)
    wr_done = 1'b0;
    tick();                             // PICK (wr_done + 2)
    checks++;
    if (wr_en !== 1'b0 || frame_cnt !== 32'd1) begin
      errors++;
      $display("FAIL done_plus2: wr_en=%b frame_cnt=%0d expected 0 1", wr_en, frame_cnt);
    end
    tick();                             // ARM (wr_done + 3)
    checks++;
    if (wr_en !== 1'b1 || wr_address !== BUF1) begin
      errors++;
      $display("FAIL done_plus3: wr_en=%b wr_address=%h expected 1 %h", wr_en, wr_address, BUF1);
    end
    finish_frame();
    wait_arm(BUF0, "third_frame_buf0");
    // Stop during WAIT: the frame still completes, then the FSM idles.
    tick();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL stop_no_abort: busy got %b expected 1", busy);
    end
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    tick();                             // leaves COMMIT into IDLE
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 32'd3) begin
      errors++;
      $display("FAIL stop_idle: busy=%b frame_cnt=%0d expected 0 3", busy, frame_cnt);
    end
    begin
      bit armed = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        armed |= wr_en;
      end
      checks++;
      if (armed) begin
        errors++;
        $display("FAIL stop_stays_idle: wr_en got 1 expected 0");
      end
    end
  endtask

  // T2: reader locks buf0, writer alternates buf1/buf2.
  task automatic test_reader_lock();
    apply_reset();
    pulse_start();
    wait_arm(BUF0, "lock_first_buf0");
    finish_frame();                     // COMMIT
    tick();                             // PICK, latest = 0
    rd_req = 1'b1;
    tick();                             // ARM, grant visible
    rd_req = 1'b0;
    checks++;
    if (rd_grant !== 1'b1 || rd_address !== BUF0) begin
      errors++;
      $display("FAIL grant_buf0: rd_grant=%b rd_address=%h expected 1 %h", rd_grant, rd_address, BUF0);
    end
    checks++;
    if (wr_en !== 1'b1 || wr_address !== BUF1) begin
      errors++;
      $display("FAIL lock_arm_buf1: wr_en=%b wr_address=%h expected 1 %h", wr_en, wr_address, BUF1);
    end
    tick();
    checks++;
    if (rd_grant !== 1'b0) begin
      errors++;
      $display("FAIL grant_pulse: rd_grant got %b expected 0", rd_grant);
    end
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    wait_arm(BUF2, "lock_alt_buf2");
    finish_frame();
    wait_arm(BUF1, "lock_alt_buf1");
    finish_frame();
    wait_arm(BUF2, "lock_alt_buf2b");
    // A second request while locked must be ignored.
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    checks++;
    if (rd_grant !== 1'b0 || rd_address !== BUF0) begin
      errors++;
      $display("FAIL req_while_locked: rd_grant=%b rd_address=%h expected 0 %h", rd_grant, rd_address, BUF0);
    end
  endtask

  // T3: request in the COMMIT cycle of buf1 gets buf0; next write goes to buf2.
  task automatic test_commit_grant();
    apply_reset();
    pulse_start();
    wait_arm(BUF0, "cg_buf0");
    finish_frame();
    wait_arm(BUF1, "cg_buf1");
    finish_frame();                     // now in COMMIT of buf1
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checks++;
    if (rd_grant !== 1'b1 || rd_address !== BUF0) begin
      errors++;
      $display("FAIL commit_cycle_grant: rd_grant=%b rd_address=%h expected 1 %h", rd_grant, rd_address, BUF0);
    end
    wait_arm(BUF2, "cg_next_buf2");
  endtask

  // T4: single-frame mode, lock rules, release priority, stop ignored in IDLE.
  task automatic test_single_and_release();
    apply_reset();
    cfg_continuous = 1'b0;
    pulse_start();
    wait_arm(BUF0, "single_buf0");
    finish_frame();
    tick();
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 32'd1) begin
      errors++;
      $display("FAIL single_idle: busy=%b frame_cnt=%0d expected 0 1", busy, frame_cnt);
    end
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checks++;
    if (rd_grant !== 1'b1 || rd_address !== BUF0) begin
      errors++;
      $display("FAIL single_grant: rd_grant=%b rd_address=%h expected 1 %h", rd_grant, rd_address, BUF0);
    end
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checks++;
    if (rd_grant !== 1'b0) begin
      errors++;
      $display("FAIL single_locked_req: rd_grant got %b expected 0", rd_grant);
    end
    rd_req     = 1'b1;
    rd_release = 1'b1;
    tick();
    rd_req     = 1'b0;
    rd_release = 1'b0;
    checks++;
    if (rd_grant !== 1'b0) begin
      errors++;
      $display("FAIL release_wins: rd_grant got %b expected 0", rd_grant);
    end
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checks++;
    if (rd_grant !== 1'b1) begin
      errors++;
      $display("FAIL grant_after_release: rd_grant got %b expected 1", rd_grant);
    end
    // Stop pulse in IDLE must not stick; a continuous run keeps re-arming.
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    cfg_continuous = 1'b1;
    pulse_start();
    wait_arm(BUF1, "rerun_buf1");
    finish_frame();
    wait_arm(BUF2, "rerun_buf2");
  endtask

  // T5: asynchronous reset in the middle of WAIT.
  task automatic test_reset_mid_frame();
    apply_reset();
    pulse_start();
    wait_arm(BUF0, "rm_buf0");
    finish_frame();
    wait_arm(BUF1, "rm_buf1");
    tick();                             // WAIT
    checks++;
    if (frame_cnt !== 32'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: frame_cnt=%0d busy=%b expected 1 1", frame_cnt, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_en, busy, rd_grant} !== 3'b000 || wr_address !== 32'h0 ||
        rd_address !== 32'h0 || frame_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_wait: wr_en=%b busy=%b wr_address=%h frame_cnt=%0d expected all zero",
               wr_en, busy, wr_address, frame_cnt);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

`ifdef IMAGE_STORE_DROP_CNT_EN
  // T6: five commits without a reader drop four frames.
  task automatic test_drop_cnt();
    apply_reset();
    pulse_start();
    wait_arm(BUF0, "drop_f1");
    finish_frame();
    wait_arm(BUF1, "drop_f2");
    finish_frame();
    wait_arm(BUF0, "drop_f3");
    finish_frame();
    wait_arm(BUF1, "drop_f4");
    finish_frame();
    wait_arm(BUF0, "drop_f5");
    cfg_continuous = 1'b0;
    finish_frame();
    tick();
    checks++;
    if (drop_cnt !== 16'd4 || frame_cnt !== 32'd5) begin
      errors++;
      $display("FAIL drop_cnt: drop_cnt=%0d frame_cnt=%0d expected 4 5", drop_cnt, frame_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_reader_lock();
    test_commit_grant();
    test_single_and_release();
    test_reset_mid_frame();
`ifdef IMAGE_STORE_DROP_CNT_EN
    test_drop_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
